apb_cordic_regfile: RTL and testbench
=====================================

// Module: apb_cordic_regfile
// PURPOSE
//  APB3 slave register front-end sitting directly upstream of the CORDIC control FSM.
//  Holds operands a/b/c/d, function select, fixed-point config and the 32-entry INVTAN table.
//  Issues a one-cycle cordic_start pulse and captures out1..out6 when the FSM pulses write_op.
//  Exposes BUSY/DONE/ERR status to software.
// PARAMETERS
//  RST_XYFRACBASE     5'd16          reset value of XYFRACBASE
//  RST_PHASEFRACBASE  5'd16          reset value of PHASEFRACBASE
//  RST_XYBASEONE      32'h0001_0000  reset value of XYBASEONE (1.0 at frac 16)
//  RST_SCALE_FACTOR   32'h0000_9B75  reset value of SCALE_FACTOR (0.60725 at frac 16)
// PORTS
//  clk            in   1     clock
//  rst_n          in   1     synchronous active-low reset
//  psel           in   1     APB select
//  penable        in   1     APB enable (access phase)
//  pwrite         in   1     APB write
//  paddr          in   8     APB byte address; [1:0] ignored
//  pwdata         in   32    APB write data
//  prdata         out  32    APB read data
//  pready         out  1     tied 1 (zero wait states)
//  pslverr        out  1     APB error, valid in access phase
//  cordic_start   out  1     one-cycle start pulse to FSM
//  cordic_func    out  3     function select
//  a, b, c, d     out  32    operand registers (4 ports)
//  xyfracbase     out  5     config
//  phasefracbase  out  5     config
//  scale_factor   out  32    config
//  xybaseone      out  32    config
//  invtan_flat    out  1024  INVTAN[k] on bits [32k+31:32k]
//  res_flat       in   192   FSM out1..out6; out(n+1) on bits [32n+31:32n]
//  write_op       in   1     FSM result-valid pulse
//  irq            out  1     level interrupt (see CONFIGURATION)
// BEHAVIOUR
//  Map (byte addr): 00 CTRL W:[0]START self-clearing, [6:4]FUNC; R:[6:4]FUNC | 04 STATUS R:[0]BUSY
//   [1]DONE [2]ERR, W1C on [1],[2] | 08/0C/10/14 A/B/C/D | 18 XYFRACBASE[4:0] | 1C PHASEFRACBASE[4:0]
//   | 20 SCALE_FACTOR | 24 XYBASEONE | 28..3C OUT1..OUT6 RO | 40 IRQ_EN[0] | 80..FC INVTAN0..31.
//  Write commits on psel&penable&pwrite; read: prdata combinational, =0 unless psel&~pwrite.
//  pslverr=1 (access phase only), no state change except ERR<=1, for: unmapped addr; write to
//   OUT*; write to A..INVTAN31 or CTRL while BUSY; START with FUNC in 5..7.
//  Valid START write (BUSY=0, FUNC 0..4): FUNC latched, cordic_start=1 next cycle for exactly 1
//   cycle, BUSY<=1 same edge, DONE<=0. START=0 write just updates FUNC.
//  write_op=1: OUT1..6 <= res_flat, BUSY<=0, DONE<=1. write_op while BUSY=0: still captured.
//  Same cycle W1C DONE and write_op: set wins (DONE=1). Same for ERR set vs W1C.
//  Reset: all operand/OUT/INVTAN/IRQ_EN regs 0, FUNC 0, config regs = RST_* params,
//   BUSY=DONE=ERR=0, cordic_start=0, irq=0, pslverr=0. Reset mid-op clears BUSY; FSM resets on
//   the same rst_n so no stale write_op follows.
// CONFIGURATION
//  CORDIC_IRQ_EN defined: IRQ_EN reg at 0x40 R/W; irq = IRQ_EN & (DONE|ERR), registered.
//  Not defined: 0x40 reads 0, writes accepted and ignored (no pslverr), irq tied 0.
// TESTING
//  Reset -> read 0x18=16, 0x24=0x00010000, 0x20=0x9B75, 0x04=0, cordic_start/irq=0.
//  Write A=0x4000, CTRL=0x01 -> cordic_start one cycle, func=0, STATUS=1; write_op with
//   res=1,2,3,0,0,0 -> OUT1..3=1,2,3, STATUS=0x2.
//  While BUSY write A=5 and CTRL=0x11 -> pslverr=1 both, A unchanged, no pulse, ERR=1.
//  CTRL=0x51 (FUNC=5) -> pslverr=1, no start, BUSY=0, ERR=1; write 0x4 to STATUS -> ERR=0.
//  Read 0xC4 (INVTAN17) after writing 0x1234 -> 0x1234; read 0x44 -> pslverr=1, prdata=0.
//  CORDIC_IRQ_EN: IRQ_EN=1, complete op -> irq=1; W1C DONE same cycle as write_op -> DONE stays 1.

Source files
------------

// File: rtl/apb_cordic_regfile.sv
// apb_cordic_regfile: APB3 register front-end for the CORDIC control FSM (operands, config, INVTAN, status).
// Optional IRQ_EN register and registered irq output when CORDIC_IRQ_EN is defined.
module apb_cordic_regfile #(
    parameter logic [4:0]  RST_XYFRACBASE    = 5'd16,
    parameter logic [4:0]  RST_PHASEFRACBASE = 5'd16,
    parameter logic [31:0] RST_XYBASEONE     = 32'h0001_0000,
    parameter logic [31:0] RST_SCALE_FACTOR  = 32'h0000_9B75
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [7:0]    paddr,
    input  logic [31:0]   pwdata,
    output logic [31:0]   prdata,
    output logic          pready,
    output logic          pslverr,
    output logic          cordic_start,
    output logic [2:0]    cordic_func,
    output logic [31:0]   a,
    output logic [31:0]   b,
    output logic [31:0]   c,
    output logic [31:0]   d,
    output logic [4:0]    xyfracbase,
    output logic [4:0]    phasefracbase,
    output logic [31:0]   scale_factor,
    output logic [31:0]   xybaseone,
    output logic [1023:0] invtan_flat,
    input  logic [191:0]  res_flat,
    input  logic          write_op,
    output logic          irq
);
    logic [31:0] invtan [32];
    logic [31:0] outr [6];
    logic        busy, done, err, irq_en;
    logic [5:0]  idx;
    logic [2:0]  oi;
    logic [31:0] rd;
    logic        acc, unmapped, is_out, locked, bad_start, bad, we, start_ok, unused_ok;

    assign idx       = paddr[7:2];
    assign oi        = idx[2:0] - 3'd2;
    assign acc       = psel & penable;
    assign unmapped  = idx > 6'd16 && !idx[5];
    assign is_out    = idx >= 6'd10 && idx <= 6'd15;
    assign locked    = idx == 6'd0 || (idx >= 6'd2 && idx <= 6'd9) || idx[5];
    assign bad_start = idx == 6'd0 && pwdata[0] && pwdata[6:4] > 3'd4;
    assign bad       = unmapped | (pwrite & (is_out | (busy & locked) | bad_start));
    assign pslverr   = acc & bad;
    assign we        = acc & pwrite & ~bad;
    assign start_ok  = we && idx == 6'd0 && pwdata[0];
    assign pready    = 1'b1;
    assign unused_ok = &{1'b0, paddr[1:0]};

    genvar k;
    generate
        for (k = 0; k < 32; k++) begin : g_inv
            assign invtan_flat[32*k +: 32] = invtan[k];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {a, b, c, d} <= '0;
            cordic_func   <= '0;
            xyfracbase    <= RST_XYFRACBASE;
            phasefracbase <= RST_PHASEFRACBASE;
            scale_factor  <= RST_SCALE_FACTOR;
            xybaseone     <= RST_XYBASEONE;
            cordic_start  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            for (int i = 0; i < 32; i++) invtan[i] <= '0;
            for (int i = 0; i < 6; i++) outr[i] <= '0;
        end else begin
            if (we) begin
                case (idx)
                    6'd0: cordic_func <= pwdata[6:4];
                    6'd2: a <= pwdata;
                    6'd3: b <= pwdata;
                    6'd4: c <= pwdata;
                    6'd5: d <= pwdata;
                    6'd6: xyfracbase <= pwdata[4:0];
                    6'd7: phasefracbase <= pwdata[4:0];
                    6'd8: scale_factor <= pwdata;
                    6'd9: xybaseone <= pwdata;
                    default: if (idx[5]) invtan[idx[4:0]] <= pwdata;
                endcase
            end
            if (write_op)
                for (int i = 0; i < 6; i++) outr[i] <= res_flat[32*i +: 32];
            cordic_start <= start_ok;
            busy <= start_ok ? 1'b1 : write_op ? 1'b0 : busy;
            // Result arrival beats both a fresh start and a software W1C in the same cycle
            done <= write_op ? 1'b1 : start_ok ? 1'b0 : done & ~(we && idx == 6'd1 && pwdata[1]);
            err  <= pslverr | (err & ~(we && idx == 6'd1 && pwdata[2]));
        end
    end

`ifdef CORDIC_IRQ_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (we && idx == 6'd16) irq_en <= pwdata[0];
            irq <= irq_en & (done | err);
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        rd = '0;
        case (idx)
            6'd0:  rd = {25'd0, cordic_func, 4'd0};
            6'd1:  rd = {29'd0, err, done, busy};
            6'd2:  rd = a;
            6'd3:  rd = b;
            6'd4:  rd = c;
            6'd5:  rd = d;
            6'd6:  rd = {27'd0, xyfracbase};
            6'd7:  rd = {27'd0, phasefracbase};
            6'd8:  rd = scale_factor;
            6'd9:  rd = xybaseone;
            6'd16: rd = {31'd0, irq_en};
            default: rd = is_out ? outr[oi] : idx[5] ? invtan[idx[4:0]] : 32'd0;
        endcase
        prdata = (psel & ~pwrite) ? rd : 32'd0;
    end
endmodule

// File: tb/tb_apb_cordic_regfile.sv
// tb_apb_cordic_regfile: directed and randomized checks of the CORDIC APB register front-end.
// Random traffic is scored against a word-array model of the register map.
module tb_apb_cordic_regfile;
    logic          clk = 0, rst_n = 0;
    logic          psel = 0, penable = 0, pwrite = 0;
    logic [7:0]    paddr = 0;
    logic [31:0]   pwdata = 0, prdata;
    logic          pready, pslverr, cordic_start, irq, write_op = 0;
    logic [2:0]    cordic_func;
    logic [31:0]   a, b, c, d, scale_factor, xybaseone;
    logic [4:0]    xyfracbase, phasefracbase;
    logic [1023:0] invtan_flat;
    logic [191:0]  res_flat = 0;

    int checks = 0, failures = 0;

    logic [31:0] m_reg [64];
    logic [2:0]  m_func;
    logic        m_busy, m_done, m_err, m_irqen;

    apb_cordic_regfile dut (
        .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .cordic_start(cordic_start), .cordic_func(cordic_func), .a(a), .b(b), .c(c), .d(d),
        .xyfracbase(xyfracbase), .phasefracbase(phasefracbase), .scale_factor(scale_factor),
        .xybaseone(xybaseone), .invtan_flat(invtan_flat), .res_flat(res_flat),
        .write_op(write_op), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_reg[i] = 0;
        m_reg[6] = 16; m_reg[7] = 16; m_reg[8] = 32'h9B75; m_reg[9] = 32'h0001_0000;
        m_func = 0; m_busy = 0; m_done = 0; m_err = 0; m_irqen = 0;
    endtask

    task automatic do_reset();
        psel = 0; penable = 0; pwrite = 0; write_op = 0;
        @(negedge clk); rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        model_reset();
    endtask

    task automatic bus(input logic w, input logic [7:0] ad, input logic [31:0] dt,
                       output logic [31:0] rd, output logic er);
        @(negedge clk); psel = 1; penable = 0; pwrite = w; paddr = ad; pwdata = dt;
        @(negedge clk); penable = 1;
        #1 rd = prdata; er = pslverr;
        @(posedge clk);
        #1 psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic pulse_wo(input logic [191:0] res);
        @(negedge clk); res_flat = res; write_op = 1;
        @(negedge clk); write_op = 0;
        for (int i = 0; i < 6; i++) m_reg[10+i] = res[32*i +: 32];
        m_busy = 0; m_done = 1;
    endtask

    function automatic logic [31:0] mread(input int k);
        if (k == 0) return {25'd0, m_func, 4'd0};
        if (k == 1) return {29'd0, m_err, m_done, m_busy};
`ifdef CORDIC_IRQ_EN
        if (k == 16) return {31'd0, m_irqen};
`else
        if (k == 16) return 0;
`endif
        return m_reg[k];
    endfunction

    task automatic mdl(input logic w, input logic [7:0] ad, input logic [31:0] dt,
                       output logic [31:0] xrd, output logic xer, output logic xst);
        int k = ad / 4;
        logic unm = k > 16 && k < 32;
        logic ro = k >= 10 && k <= 15;
        logic lock = m_busy && (k == 0 || (k >= 2 && k <= 9) || k >= 32);
        logic bf = k == 0 && dt[0] && dt[6:4] > 4;
        xer = unm || (w && (ro || lock || bf));
        xrd = w ? 32'd0 : mread(k);
        xst = 0;
        if (xer) m_err = 1;
        else if (w) begin
            if (k == 0) begin
                m_func = dt[6:4];
                if (dt[0]) begin xst = 1; m_busy = 1; m_done = 0; end
            end else if (k == 1) begin
                if (dt[1]) m_done = 0;
                if (dt[2]) m_err = 0;
            end else if (k == 6 || k == 7) m_reg[k] = {27'd0, dt[4:0]};
            else if (k == 16) m_irqen = dt[0];
            else m_reg[k] = dt;
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er;
        do_reset();
        checks++; if (cordic_start !== 0 || irq !== 0 || pslverr !== 0) begin failures++;
            $display("FAIL reset_outs start=%0b irq=%0b slverr=%0b want 0", cordic_start, irq, pslverr); end
        bus(0, 8'h18, 0, rd, er);
        checks++; if (rd !== 16 || er !== 0) begin failures++; $display("FAIL rst_xyfrac got %h/%0b want 10/0", rd, er); end
        bus(0, 8'h1C, 0, rd, er);
        checks++; if (rd !== 16) begin failures++; $display("FAIL rst_phfrac got %h want 10", rd); end
        bus(0, 8'h24, 0, rd, er);
        checks++; if (rd !== 32'h0001_0000) begin failures++; $display("FAIL rst_xyone got %h want 00010000", rd); end
        bus(0, 8'h20, 0, rd, er);
        checks++; if (rd !== 32'h9B75) begin failures++; $display("FAIL rst_scale got %h want 9b75", rd); end
        bus(0, 8'h04, 0, rd, er);
        checks++; if (rd !== 0) begin failures++; $display("FAIL rst_status got %h want 0", rd); end
        checks++; if (a !== 0 || invtan_flat !== 0 || pready !== 1) begin failures++;
            $display("FAIL rst_regs a=%h pready=%0b want 0/1", a, pready); end
    endtask

    task automatic test_start();
        logic [31:0] rd; logic er;
        bus(1, 8'h08, 32'h4000, rd, er);
        checks++; if (er !== 0 || a !== 32'h4000) begin failures++; $display("FAIL wr_a got %h/%0b want 4000/0", a, er); end
        bus(1, 8'h00, 32'h01, rd, er);
        checks++; if (cordic_start !== 1 || cordic_func !== 0 || er !== 0) begin failures++;
            $display("FAIL start_pulse start=%0b func=%0d want 1/0", cordic_start, cordic_func); end
        @(posedge clk); #1;
        checks++; if (cordic_start !== 0) begin failures++; $display("FAIL start_width got %0b want 0", cordic_start); end
        bus(0, 8'h04, 0, rd, er);
        checks++; if (rd !== 1) begin failures++; $display("FAIL status_busy got %h want 1", rd); end
        pulse_wo({96'd0, 32'd3, 32'd2, 32'd1});
        for (int i = 0; i < 3; i++) begin
            bus(0, 8'h28 + 8'(4*i), 0, rd, er);
            checks++; if (rd !== 32'(i + 1)) begin failures++; $display("FAIL out%0d got %h want %0d", i + 1, rd, i + 1); end
        end
        bus(0, 8'h04, 0, rd, er);
        checks++; if (rd !== 2) begin failures++; $display("FAIL status_done got %h want 2", rd); end
    endtask

    task automatic test_busy_err();
        logic [31:0] rd; logic er;
        bus(1, 8'h00, 32'h01, rd, er);
        bus(1, 8'h08, 32'h5, rd, er);
        checks++; if (er !== 1 || a !== 32'h4000) begin failures++; $display("FAIL busy_wr_a slverr=%0b a=%h want 1/4000", er, a); end
        bus(1, 8'h00, 32'h11, rd, er);
        checks++; if (er !== 1 || cordic_start !== 0 || cordic_func !== 0) begin failures++;
            $display("FAIL busy_ctrl slverr=%0b start=%0b func=%0d want 1/0/0", er, cordic_start, cordic_func); end
        bus(0, 8'h04, 0, rd, er);
        checks++; if (rd !== 5) begin failures++; $display("FAIL busy_status got %h want 5", rd); end
        pulse_wo(0);
        bus(1, 8'h04, 32'h6, rd, er);
        bus(0, 8'h04, 0, rd, er);
        checks++; if (rd !== 0) begin failures++; $display("FAIL w1c_both got %h want 0", rd); end
    endtask

    task automatic test_bad_func();
        logic [31:0] rd; logic er;
        bus(1, 8'h00, 32'h51, rd, er);
        checks++; if (er !== 1 || cordic_start !== 0) begin failures++; $display("FAIL bad_func slverr=%0b start=%0b want 1/0", er, cordic_start); end
        bus(0, 8'h04, 0, rd, er);
        checks++; if (rd !== 4) begin failures++; $display("FAIL bad_func_status got %h want 4", rd); end
        bus(1, 8'h04, 32'h4, rd, er);
        bus(0, 8'h04, 0, rd, er);
        checks++; if (rd !== 0) begin failures++; $display("FAIL err_clear got %h want 0", rd); end
        bus(1, 8'h00, 32'h60, rd, er);
        checks++; if (er !== 0 || cordic_func !== 6 || cordic_start !== 0) begin failures++;
            $display("FAIL func_only slverr=%0b func=%0d want 0/6", er, cordic_func); end
        bus(1, 8'h30, 32'h9, rd, er);
        checks++; if (er !== 1) begin failures++; $display("FAIL wr_out slverr=%0b want 1", er); end
        bus(1, 8'h04, 32'h4, rd, er);
    endtask

    task automatic test_invtan();
        logic [31:0] rd; logic er;
        bus(1, 8'hC4, 32'h1234, rd, er);
        bus(0, 8'hC4, 0, rd, er);
        checks++; if (rd !== 32'h1234 || invtan_flat[17*32 +: 32] !== 32'h1234) begin failures++;
            $display("FAIL invtan17 got %h want 1234", rd); end
        bus(0, 8'h44, 0, rd, er);
        checks++; if (er !== 1 || rd !== 0) begin failures++; $display("FAIL unmapped slverr=%0b rd=%h want 1/0", er, rd); end
        bus(1, 8'h04, 32'h4, rd, er);
    endtask

    task automatic test_irq();
        logic [31:0] rd; logic er;
        bus(1, 8'h40, 32'h1, rd, er);
        checks++; if (er !== 0) begin failures++; $display("FAIL irqen_wr slverr=%0b want 0", er); end
        bus(1, 8'h00, 32'h21, rd, er);
        @(negedge clk); psel = 1; penable = 0; pwrite = 1; paddr = 8'h04; pwdata = 32'h2;
        @(negedge clk); penable = 1; write_op = 1; res_flat = 192'd7;
        @(posedge clk); #1 psel = 0; penable = 0; pwrite = 0; write_op = 0;
        bus(0, 8'h04, 0, rd, er);
        checks++; if (rd !== 2) begin failures++; $display("FAIL w1c_vs_wo got %h want 2", rd); end
        bus(0, 8'h40, 0, rd, er);
`ifdef CORDIC_IRQ_EN
        checks++; if (rd !== 1 || irq !== 1) begin failures++; $display("FAIL irq rd=%h irq=%0b want 1/1", rd, irq); end
`else
        checks++; if (rd !== 0 || irq !== 0) begin failures++; $display("FAIL irq_off rd=%h irq=%0b want 0/0", rd, irq); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] rd, xrd, dt; logic er, xer, xst, w; logic [7:0] ad;
        do_reset();
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 5) == 0) pulse_wo({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            w  = 1'($urandom_range(0, 1));
            ad = 8'($urandom_range(0, 63) << 2);
            dt = $urandom;
            if (ad == 8'h00 && $urandom_range(0, 1) == 1) dt[6:4] = 3'($urandom_range(0, 4));
            mdl(w, ad, dt, xrd, xer, xst);
            bus(w, ad, dt, rd, er);
            checks++; if (rd !== xrd || er !== xer || cordic_start !== xst) begin failures++;
                $display("FAIL rand w=%0b ad=%h rd=%h/%0b/%0b want %h/%0b/%0b", w, ad, rd, er, cordic_start, xrd, xer, xst); end
        end
        checks++; if ({a, b, c, d} !== {m_reg[2], m_reg[3], m_reg[4], m_reg[5]} || cordic_func !== m_func) begin failures++;
            $display("FAIL rand_ops a=%h b=%h func=%0d want %h %h %0d", a, b, cordic_func, m_reg[2], m_reg[3], m_func); end
        for (int i = 0; i < 32; i++) begin
            checks++; if (invtan_flat[32*i +: 32] !== m_reg[32+i]) begin failures++;
                $display("FAIL rand_invtan%0d got %h want %h", i, invtan_flat[32*i +: 32], m_reg[32+i]); end
        end
        checks++; if (scale_factor !== m_reg[8] || xybaseone !== m_reg[9] || xyfracbase !== m_reg[6][4:0] || phasefracbase !== m_reg[7][4:0]) begin
            failures++; $display("FAIL rand_cfg scale=%h want %h", scale_factor, m_reg[8]); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_busy_err();
        test_bad_func();
        test_invtan();
        test_irq();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
